// File: rtl/counter_run_scheduler.sv
// counter_run_scheduler
//   Shares one 2-bit wrap counter between two requesters. A granted requester
//   gets a run of a programmable number of counter wrap-arounds, with enable
//   pulses paced by a shared divider. The scheduler clears the counter,
//   issues the paced enables, counts wrap flags and pulses completion.
//
// Ports
//   clk, reset   clock and synchronous active-high reset
//   req[1:0]     level requests, held until the matching done pulse
//   len0, len1   wraps per run for requester 0 / 1 (latched at grant)
//   div          extra idle cycles between enable pulses (latched at grant)
//   abort        ends a run in CLR/RUN without a done pulse
//   z_in         counter wrap flag (registered, changes on enabled edges only)
//   x_out        counter enable pulse
//   cnt_reset    counter synchronous clear
//   gnt[1:0]     one-hot grant, held for the whole run
//   done[1:0]    one-cycle completion pulse per requester
//   busy         high in any state other than IDLE
module counter_run_scheduler #(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [DIV_W-1:0] div,
  input  logic             abort,
  input  logic             z_in,
  output logic             x_out,
  output logic             cnt_reset,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy
);

  // Phase counter must reach div+1, one bit wider than div.
  localparam int unsigned PH_W = DIV_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    RUN,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       gnt_q, gnt_nxt;
  logic             ptr_q, ptr_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic [DIV_W-1:0] div_q, div_nxt;
  logic [PH_W-1:0]  ph_q, ph_nxt;
  logic [LEN_W-1:0] wraps_q, wraps_nxt;

  logic [PH_W-1:0]  ph_last;
  logic [LEN_W-1:0] wraps_inc;
  logic             sel;
  logic             abort_hit;

  // Datapath helpers.
  always_comb begin
    ph_last   = {1'b0, div_q} + PH_W'(1);
    wraps_inc = wraps_q + LEN_W'(1);
    abort_hit = abort && ((state == CLR) || (state == RUN));
    // Both requesting: pointer decides. One requesting: that one wins.
    sel       = (req == 2'b11) ? ptr_q : req[1];
  end

  // State and run registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= 1'b0;
      len_q   <= '0;
      div_q   <= '0;
      ph_q    <= '0;
      wraps_q <= '0;
    end else begin
      state   <= state_nxt;
      gnt_q   <= gnt_nxt;
      ptr_q   <= ptr_nxt;
      len_q   <= len_nxt;
      div_q   <= div_nxt;
      ph_q    <= ph_nxt;
      wraps_q <= wraps_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    ptr_nxt   = ptr_q;
    len_nxt   = len_q;
    div_nxt   = div_q;
    ph_nxt    = ph_q;
    wraps_nxt = wraps_q;

    unique case (state)
      IDLE: begin
        if (req != 2'b00) begin
          gnt_nxt   = sel ? 2'b10 : 2'b01;
          len_nxt   = sel ? len1 : len0;
          div_nxt   = div;
          state_nxt = CLR;
        end
      end

      CLR: begin
        ph_nxt    = '0;
        wraps_nxt = '0;
        if (abort) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = ~ptr_q;
        end else if (len_q == '0) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
        end
      end

      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = ~ptr_q;
        end else begin
          ph_nxt = (ph_q == ph_last) ? '0 : ph_q + PH_W'(1);
          // z_in is only meaningful one cycle after a pulse.
          if ((ph_q == PH_W'(1)) && z_in) begin
            wraps_nxt = wraps_inc;
            if (wraps_inc == len_q) begin
              state_nxt = DONE;
            end
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        ptr_nxt   = ~ptr_q;
      end

      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    gnt       = gnt_q;
    busy      = (state != IDLE);
    x_out     = (state == RUN) && (ph_q == '0);
    done      = (state == DONE) ? gnt_q : 2'b00;
    cnt_reset = reset || (state == CLR) || abort_hit;
  end

endmodule

// File: tb/tb_counter_run_scheduler.sv
module tb_counter_run_scheduler;

  localparam int unsigned LEN_W = 4;
  localparam int unsigned DIV_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic [DIV_W-1:0] div;
  logic             abort;
  logic             z_in;
  logic             x_out;
  logic             cnt_reset;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             busy;

  counter_run_scheduler #(
    .LEN_W(LEN_W),
    .DIV_W(DIV_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .len0     (len0),
    .len1     (len1),
    .div      (div),
    .abort    (abort),
    .z_in     (z_in),
    .x_out    (x_out),
    .cnt_reset(cnt_reset),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Cycle index: constant between consecutive posedges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the shared 2-bit wrap counter feeding z_in.
  logic [1:0] cnt_m;
  always @(posedge clk) begin
    if (cnt_reset) begin
      cnt_m <= 2'd0;
      z_in  <= 1'b0;
    end else if (x_out) begin
      cnt_m <= cnt_m + 2'd1;
      z_in  <= (cnt_m == 2'd3);
    end
  end

  typedef struct {
    logic [1:0] who;
    int         cyc;
    int         pulses;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses   = 0;
  int   t0       = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [1:0] who, input int c, input int p);
    exp_t e;
    e.who = who;
    e.cyc = c;
    e.pulses = p;
    exp_q.push_back(e);
  endtask

  // Start a step: returns in the new cycle just after its posedge.
  task automatic begin_step();
    @(posedge clk);
    #1;
    t0 = cyc;
  endtask

  // Move to the sampling point (negedge) of cycle c.
  task automatic at_cycle(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done pulse must match the next expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (done !== 2'b00) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", {30'b0, done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_who", {30'b0, done}, {30'b0, e.who});
        check("done_cycle", cyc, e.cyc);
        check("run_pulses", pulses, e.pulses);
      end
    end
    if (busy !== 1'b1) pulses = 0;
    else if (x_out === 1'b1) pulses++;
  end

  initial begin
    reset = 1'b1;
    req   = 2'b00;
    len0  = '0;
    len1  = '0;
    div   = '0;
    abort = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_cnt_reset", {31'b0, cnt_reset}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_gnt", {30'b0, gnt}, 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("idle_cnt_reset", {31'b0, cnt_reset}, 32'd0);
    check("idle_x_out", {31'b0, x_out}, 32'd0);
    check("idle_done", {30'b0, done}, 32'd0);

    // Single run: req0, len 1, div 0.
    len0 = 4'd1;
    div  = 4'd0;
    begin_step();
    req = 2'b01;
    push(2'b01, t0 + 10, 4);
    at_cycle(t0 + 1);
    check("t1_gnt", {30'b0, gnt}, 32'd1);
    check("t1_clr", {31'b0, cnt_reset}, 32'd1);
    check("t1_busy", {31'b0, busy}, 32'd1);
    at_cycle(t0 + 2);
    check("t1_pulse0", {31'b0, x_out}, 32'd1);
    at_cycle(t0 + 3);
    check("t1_gap", {31'b0, x_out}, 32'd0);
    at_cycle(t0 + 10);
    next_cycle();
    req = 2'b00;
    at_cycle(t0 + 11);
    check("t1_busy_fall", {31'b0, busy}, 32'd0);
    check("t1_gnt_off", {30'b0, gnt}, 32'd0);

    // Pulse spacing: len 2, div 3.
    len0 = 4'd2;
    div  = 4'd3;
    begin_step();
    req = 2'b01;
    push(2'b01, t0 + 39, 8);
    at_cycle(t0 + 2);
    check("t2_pulse0", {31'b0, x_out}, 32'd1);
    at_cycle(t0 + 4);
    check("t2_gap", {31'b0, x_out}, 32'd0);
    at_cycle(t0 + 7);
    check("t2_pulse1", {31'b0, x_out}, 32'd1);
    at_cycle(t0 + 39);
    next_cycle();
    req = 2'b00;

    // Simultaneous requests straight out of reset.
    len0 = 4'd1;
    len1 = 4'd1;
    div  = 4'd0;
    next_cycle();
    reset = 1'b1;
    begin_step();
    reset = 1'b0;
    req   = 2'b11;
    push(2'b01, t0 + 10, 4);
    push(2'b10, t0 + 21, 4);
    at_cycle(t0 + 1);
    check("t3_gnt0", {30'b0, gnt}, 32'd1);
    at_cycle(t0 + 10);
    next_cycle();
    req = 2'b10;
    at_cycle(t0 + 12);
    check("t3_gnt1", {30'b0, gnt}, 32'd2);
    at_cycle(t0 + 21);
    next_cycle();
    req = 2'b00;

    // Fairness: both held for four runs.
    begin_step();
    req = 2'b11;
    push(2'b01, t0 + 10, 4);
    push(2'b10, t0 + 21, 4);
    push(2'b01, t0 + 32, 4);
    push(2'b10, t0 + 43, 4);
    at_cycle(t0 + 12);
    check("t4_gnt_alt", {30'b0, gnt}, 32'd2);
    at_cycle(t0 + 43);
    next_cycle();
    req = 2'b00;

    // Abort in RUN; pending req1 wins via the advanced pointer.
    len0 = 4'd3;
    len1 = 4'd1;
    begin_step();
    req = 2'b01;
    at_cycle(t0 + 1);
    check("t5_gnt", {30'b0, gnt}, 32'd1);
    next_cycle();
    req = 2'b11;
    at_cycle(t0 + 3);
    next_cycle();
    abort = 1'b1;
    push(2'b10, t0 + 15, 4);
    at_cycle(t0 + 4);
    check("t5_abort_clr", {31'b0, cnt_reset}, 32'd1);
    next_cycle();
    abort = 1'b0;
    at_cycle(t0 + 5);
    check("t5_gnt_off", {30'b0, gnt}, 32'd0);
    check("t5_busy_off", {31'b0, busy}, 32'd0);
    at_cycle(t0 + 6);
    check("t5_gnt_next", {30'b0, gnt}, 32'd2);
    at_cycle(t0 + 15);
    next_cycle();
    req = 2'b00;

    // len0 = 0: CLR then DONE, no pulses.
    len0 = 4'd0;
    begin_step();
    req = 2'b01;
    push(2'b01, t0 + 2, 0);
    at_cycle(t0 + 1);
    check("t6_clr", {31'b0, cnt_reset}, 32'd1);
    check("t6_no_pulse", {31'b0, x_out}, 32'd0);
    at_cycle(t0 + 2);
    check("t6_busy", {31'b0, busy}, 32'd1);
    next_cycle();
    req = 2'b00;

    // Reset mid-run; pointer returns to requester 0.
    len0 = 4'd2;
    div  = 4'd1;
    begin_step();
    req = 2'b01;
    at_cycle(t0 + 5);
    next_cycle();
    reset = 1'b1;
    at_cycle(t0 + 6);
    check("t7_rst_clr", {31'b0, cnt_reset}, 32'd1);
    next_cycle();
    reset = 1'b0;
    req   = 2'b00;
    at_cycle(t0 + 7);
    check("t7_gnt", {30'b0, gnt}, 32'd0);
    check("t7_busy", {31'b0, busy}, 32'd0);
    check("t7_x_out", {31'b0, x_out}, 32'd0);
    check("t7_done", {30'b0, done}, 32'd0);
    check("t7_cnt_reset", {31'b0, cnt_reset}, 32'd0);
    len0 = 4'd0;
    len1 = 4'd0;
    begin_step();
    req = 2'b11;
    push(2'b01, t0 + 2, 0);
    at_cycle(t0 + 1);
    check("t7_ptr_gnt", {30'b0, gnt}, 32'd1);
    at_cycle(t0 + 2);
    next_cycle();
    req = 2'b00;

    repeat (4) @(negedge clk);
    check("all_done_seen", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_run_scheduler.md
# counter_run_scheduler

Sequencing controller that shares a single 2-bit wrap counter (enable input, wrap flag output) between two requesters. Each granted requester gets a run of a programmable number of counter wrap-arounds at a programmable step rate. The scheduler clears the counter, issues paced enable pulses, counts wrap flags and signals completion. It sits between the requester logic and the counter instance.

## Interface
- LEN_W, 4: width of run length (number of wraps per run).
- DIV_W, 4: width of step-rate divider.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  2  level requests; req[i] held until done[i].
- len0  in  LEN_W  wraps requested by requester 0.
- len1  in  LEN_W  wraps requested by requester 1.
- div  in  DIV_W  extra idle cycles between enable pulses (shared).
- abort  in  1  terminates the current run.
- z_in  in  1  counter wrap flag (registered; updates only on enabled edges; holds otherwise).
- x_out  out  1  counter enable pulse.
- cnt_reset  out  1  counter synchronous clear.
- gnt  out  2  one-hot grant, held for the whole run.
- done  out  2  one-cycle completion pulse per requester.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, CLR, RUN, DONE.
- IDLE:
  - If any req bit is set, grant one requester by round-robin and latch its len and div.
  - Priority pointer starts at requester 0 after reset. After each run ends (DONE or abort), the pointer moves to the other requester.
  - If only one req bit is set, that requester wins regardless of the pointer.
  - Next state is CLR.
- CLR (exactly 1 cycle): cnt_reset=1.
  - If latched len==0, next state is DONE; no x_out pulses are issued.
  - Otherwise next state is RUN; the phase counter and wrap counter are cleared.
- RUN:
  - Phase counter ph counts 0..div+1, then wraps to 0.
  - x_out=1 only when ph==0. Period is div+2 cycles, so pulses are never adjacent.
  - When ph==1, z_in is sampled; it reflects the preceding pulse.
  - z_in==1 at the sample increments the wrap count. When the wrap count equals len, next state is DONE.
  - z_in is ignored on all other phases.
- DONE (1 cycle): done[granted]=1; gnt is still asserted this cycle. Next state is IDLE with gnt=0.
- abort in CLR or RUN:
  - Next state is IDLE with gnt=0.
  - cnt_reset=1 in the cycle abort is sampled.
  - No done pulse.
  - The priority pointer advances.
- abort in IDLE or DONE: ignored.
- Dropping req during a run does not stop the run.
- len, div and req changes after grant have no effect until the next IDLE.
- cnt_reset = reset OR (state==CLR) OR (abort sampled in CLR/RUN).
- Wrap count width is LEN_W. Its compare is exact, so overflow is impossible.

## Timing
- Reset values:
  - state IDLE, gnt=0, done=0, x_out=0, busy=0, pointer=0.
  - cnt_reset=1 while reset is high.
- Reset mid-run: returns to IDLE on the next edge. No done pulse. The pointer returns to 0.
- Grant latency: gnt is high in the cycle after the IDLE cycle in which req is sampled (the CLR cycle).
- Run latency for len L≥1, div D, counting cycle 0 as the IDLE sample cycle:
  - CLR at cycle 1; first RUN cycle is cycle 2.
  - Pulse k (k = 0..4L−1) is at cycle 2 + k(D+2).
  - Final sample is at cycle 3 + (4L−1)(D+2).
  - done is at the cycle after the final sample.
- len=0: done at cycle 2.
- Back-to-back runs: at least one IDLE cycle between DONE and the next CLR.

## Test plan
- Single run, req0, len0=1, div=0:
  - gnt=01 at cycle 1; x_out pulses at cycles 2, 4, 6, 8; z_in high at cycle 9 sample.
  - done[0] at cycle 10; busy falls at cycle 11.
- Pulse spacing, len0=2, div=3: x_out period 5 cycles; 8 pulses total; done[0] at cycle 3 + 7·5 + 1 = 39.
- Simultaneous req=11 from reset, len0=len1=1, div=0:
  - gnt=01 first, done[0] at cycle 10.
  - gnt=10 next, with the IDLE sample at cycle 11; done[1] at cycle 21.
- Fairness: req0 held continuously, req1 held continuously, 4 runs → grants alternate 0, 1, 0, 1.
- len0=0: CLR then DONE; done[0] at cycle 2; no x_out pulse.
- Abort at RUN cycle 3 with len0=3:
  - cnt_reset=1 in that cycle; gnt=0 the next cycle; no done.
  - A pending req1 is granted next.
- Reset asserted mid-run: all outputs at reset values the next cycle.
